// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit.
// Divider support is compiled in only when MDU_DIV_EN is defined.
package mdu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN
  } mdu_state_e;
endpackage

// File: rtl/mdu_shift_datapath.sv
// Iterative magnitude datapath: shift-add multiplier, and (MDU_DIV_EN) restoring divider.
// Operands arrive as magnitudes; sign fix-up happens in the sequencer.
module mdu_shift_datapath #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_step,
`ifdef MDU_DIV_EN
  input  logic         i_div,
`endif
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q;
  logic [W:0]     sum;
`ifdef MDU_DIV_EN
  logic           div_q;
  logic [W-1:0]   rem_q, rem_d;
  logic [W:0]     shifted, diff;
`endif

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, consumed LSB first.
    sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_d = {sum, acc_q[W-1:1]};
`ifdef MDU_DIV_EN
    shifted = {rem_q, acc_q[W-1]};
    diff    = shifted - {1'b0, opnd_q};
    rem_d   = rem_q;
    if (div_q) begin
      rem_d = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~diff[W]};
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
`ifdef MDU_DIV_EN
      div_q  <= 1'b0;
      rem_q  <= '0;
`endif
    end else if (i_load) begin
`ifdef MDU_DIV_EN
      div_q  <= i_div;
      rem_q  <= '0;
      opnd_q <= i_div ? i_b : i_a;
      acc_q  <= {{W{1'b0}}, (i_div ? i_a : i_b)};
`else
      opnd_q <= i_a;
      acc_q  <= {{W{1'b0}}, i_b};
`endif
    end else if (i_step) begin
      acc_q <= acc_d;
`ifdef MDU_DIV_EN
      rem_q <= rem_d;
`endif
    end
  end

`ifdef MDU_DIV_EN
  assign o_hi = div_q ? rem_q : acc_q[2*W-1:W];
`else
  assign o_hi = acc_q[2*W-1:W];
`endif
  assign o_lo = acc_q[W-1:0];
endmodule

// File: rtl/mdu_sequencer.sv
// MDU controller: FSM, iteration counter, sign fix-up, HI/LO and pipeline stall.
// Divide ops are accepted only when MDU_DIV_EN is defined; otherwise they are ignored.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = mdu_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_srcA,
  input  logic [DATA_WIDTH-1:0] i_srcB,
  input  logic                  i_hi_rd,
  input  logic                  i_lo_rd,
  input  logic                  i_hi_wr,
  input  logic                  i_lo_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_cancel,
  output logic                  o_busy,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           done_q, div_q, neg_res_q, neg_rem_q, dz_q;
  logic           is_div, is_signed, op_ok, dz, accept;
  logic [W-1:0]   a_mag, b_mag, dp_hi, dp_lo, quo_fix, rem_src, rem_fix;
  logic [2*W-1:0] prod_fix;

  assign is_div    = i_op[1];
  assign is_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
`ifdef MDU_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~i_op[1];
`endif
  assign dz     = is_div & (i_srcB == '0);
  assign accept = (state_q == S_IDLE) & i_start & ~i_cancel & op_ok;
  assign a_mag  = (is_signed & i_srcA[W-1]) ? -i_srcA : i_srcA;
  assign b_mag  = (is_signed & i_srcB[W-1]) ? -i_srcB : i_srcB;

  mdu_shift_datapath #(.W(W)) u_dp (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (accept),
    .i_step (state_q == S_CALC),
`ifdef MDU_DIV_EN
    .i_div  (is_div),
`endif
    .i_a    (a_mag),
    .i_b    (b_mag),
    .o_hi   (dp_hi),
    .o_lo   (dp_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d   = '0;
        state_d = dz ? S_SIGN : S_CALC;
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (i_cancel)                         state_d = S_IDLE;
        else if (cnt_q == CW'(DATA_WIDTH-1)) state_d = S_SIGN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Divide-by-zero leaves |A| in the datapath low half; re-applying A's sign restores A exactly.
  assign prod_fix = neg_res_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
  assign quo_fix  = neg_res_q ? -dp_lo : dp_lo;
  assign rem_src  = dz_q ? dp_lo : dp_hi;
  assign rem_fix  = neg_rem_q ? -rem_src : rem_src;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_SIGN && !i_cancel) begin
      if (div_q) begin
        hi_d = rem_fix;
        lo_d = dz_q ? '1 : quo_fix;
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end else if (state_q == S_IDLE && !i_start) begin
      if (i_hi_wr) hi_d = i_wdata;
      if (i_lo_wr) lo_d = i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= (state_q == S_SIGN) & ~i_cancel;
      if (accept) begin
        div_q     <= is_div;
        neg_res_q <= is_signed & (i_srcA[W-1] ^ i_srcB[W-1]);
        neg_rem_q <= is_signed & i_srcA[W-1];
        dz_q      <= dz;
      end
    end
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_stall = o_busy & (i_start | i_hi_rd | i_lo_rd | i_hi_wr | i_lo_wr);
  assign o_done  = done_q;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer; divide vectors run when MDU_DIV_EN is defined.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hi_rd, lo_rd, hi_wr, lo_wr, cancel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_srcA(a), .i_srcB(b), .i_hi_rd(hi_rd), .i_lo_rd(lo_rd),
    .i_hi_wr(hi_wr), .i_lo_wr(lo_wr), .i_wdata(wdata), .i_cancel(cancel),
    .o_busy(busy), .o_stall(stall), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for o_done; lat counts cycles after the accepting edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; wdata = '0;
    hi_rd = 1'b0; lo_rd = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; cancel = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst.busy", busy, 0);
    chk("rst.stall", stall, 0);
    chk("rst.done", done, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);

    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    run_op("mult_neg",  MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 34);
    run_op("mult_pos",  MDU_MULT,  32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 34);
    run_op("mult_nn",   MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34);

    // MTHI / MTLO in idle
    hi_wr = 1'b1; wdata = 32'h1234;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'h5678;
    tick();
    lo_wr = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);

    // Cancel at counter 10: cycle k+11 after accepting edge k
    op = MDU_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel.busy", busy, 0);
    chk("cancel.hi", hi, 32'h1234);
    chk("cancel.lo", lo, 32'h5678);
    n = 0;
    repeat (40) begin
      if (done) n++;
      tick();
    end
    chk("cancel.nodone", n, 0);

    // MFLO one cycle after MULTU: stalled for the 33 busy cycles
    op = MDU_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; lo_rd = 1'b1;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    chk("mflo.stall_cycles", n, 33);
    chk("mflo.done", done, 1);
    chk("mflo.lo", lo, 32'd42);
    chk("mflo.hi", hi, 32'd0);
    lo_rd = 1'b0;

`ifdef MDU_DIV_EN
    run_op("div_neg",  MDU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op("divu_dz",  MDU_DIVU, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 2);
    run_op("div_ovf",  MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
    run_op("divu",     MDU_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       34);
    run_op("div_dzn",  MDU_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 2);
`else
    op = MDU_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    #1;
    chk("nodiv.stall", stall, 0);
    tick();
    start = 1'b0;
    chk("nodiv.busy", busy, 0);
    n = 0;
    repeat (40) begin
      if (done || busy) n++;
      tick();
    end
    chk("nodiv.idle", n, 0);
    chk("nodiv.hi", hi, 32'd0);
    chk("nodiv.lo", lo, 32'd42);
`endif

    // Reset mid-CALC clears HI/LO
    hi_wr = 1'b1; wdata = 32'hABCD;
    tick();
    hi_wr = 1'b0;
    chk("mthi2", hi, 32'hABCD);
    op = MDU_MULTU; a = 32'hFFFFFFFF; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("midop.busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("midrst.busy", busy, 0);
    chk("midrst.stall", stall, 0);
    chk("midrst.done", done, 0);
    chk("midrst.hi", hi, 0);
    chk("midrst.lo", lo, 0);
    rst = 1'b0;
    tick();
    run_op("post_rst", MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 34);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide unit controller for the five-stage MIPS pipeline, sitting beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU from EX, runs an iterative shift-add multiplier or restoring divider for DATA_WIDTH cycles, and owns the HI/LO registers. It services MFHI/MFLO/MTHI/MTLO and raises a pipeline stall whenever one of these, or a new MDU op, arrives while an operation is in flight.

## Interface
- DATA_WIDTH, 32: operand, HI and LO width.
- i_clk  in  1  pipeline clock; all state changes on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  MDU op valid in EX this cycle.
- i_op  in  2  op select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_srcA  in  DATA_WIDTH  rs operand (multiplicand / dividend).
- i_srcB  in  DATA_WIDTH  rt operand (multiplier / divisor).
- i_hi_rd, i_lo_rd  in  1  MFHI / MFLO in EX.
- i_hi_wr, i_lo_wr  in  1  MTHI / MTLO in EX.
- i_wdata  in  DATA_WIDTH  MTHI/MTLO data.
- i_cancel  in  1  abort in-flight op (exception flush).
- o_busy  out  1  operation in flight.
- o_stall  out  1  freeze IF/ID/EX, bubble MEM.
- o_done  out  1  one-cycle pulse: new HI/LO visible.
- o_hi, o_lo  out  DATA_WIDTH  HI/LO register contents.

## Operation
- FSM states: IDLE, CALC, SIGN. o_busy = (state != IDLE).
- IDLE: i_start & ~i_cancel latches operands and op, clears counter, enters CALC. Signed ops latch magnitudes and record result signs (product: sA^sB; quotient: sA^sB; remainder: sA).
- CALC: one iteration per cycle, counter 0..DATA_WIDTH-1; at counter = DATA_WIDTH-1 go to SIGN.
  - Multiply: 2·DATA_WIDTH-bit accumulator, add-and-shift right per multiplier bit.
  - Divide: restoring, one quotient bit per cycle, remainder DATA_WIDTH+1 bits.
- SIGN: apply two's-complement negation per recorded signs; write HI (product upper / remainder) and LO (product lower / quotient); go to IDLE.
- Divide by zero (i_srcB == 0, DIV or DIVU): skip CALC, IDLE → SIGN directly; write LO = all ones, HI = i_srcA unmodified.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no trap).
- MTHI/MTLO in IDLE without stall: HI/LO written at next edge. Same cycle as i_start: i_start wins, write dropped (cannot occur in legal code).
- MFHI/MFLO in IDLE: o_hi/o_lo read combinationally-stable register values.
- o_stall = o_busy & (i_start | i_hi_rd | i_lo_rd | i_hi_wr | i_lo_wr). A stalled i_start is not accepted; it is re-presented after busy falls.
- i_cancel: from CALC or SIGN return to IDLE next edge, HI/LO unchanged, no o_done. In IDLE it blocks acceptance of i_start.

## Timing
- Reset: state IDLE, counter 0, HI = 0, LO = 0, o_busy 0, o_stall 0, o_done 0.
- i_start accepted at edge k: CALC for cycles k+1..k+DATA_WIDTH, SIGN at k+DATA_WIDTH+1, HI/LO updated at its closing edge, o_done = 1 in cycle k+DATA_WIDTH+2 (o_busy already 0).
- Divide-by-zero: SIGN at k+1, o_done at k+2.
- Back-to-back ops: earliest next acceptance is the o_done cycle.
- i_rst mid-operation: same as reset; HI/LO cleared.

## Configuration
- MDU_DIV_EN defined: full behaviour above.
- Not defined: divider logic removed; i_start with i_op[1] = 1 is ignored (no busy, no stall, HI/LO unchanged, no o_done); multiply behaviour identical.

## Structure
- Package mdu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), FSM state enum, DATA_WIDTH default, counter width $clog2(DATA_WIDTH).
- Sub-module mdu_shift_datapath: accumulator/remainder registers and per-cycle add/subtract-shift step; mdu_sequencer holds FSM, counter, sign fix-up, HI/LO, stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001, o_done exactly 34 cycles after acceptance.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 100, o_done 2 cycles after acceptance.
- MFLO issued 1 cycle after MULT → o_stall high until o_done cycle, then o_lo shows new product.
- i_cancel at CALC counter 10 after prior MTHI 0x1234 → IDLE next cycle, HI = 0x1234, no o_done.
- i_rst asserted during CALC → next cycle all outputs at reset values; DIV rejected when MDU_DIV_EN undefined.
